rect_sprite_drawer: RTL
=======================

# rect_sprite_drawer

Per-object pixel emitter for the game's framebuffer path. On a `go` pulse it latches a top-left coordinate and colour, then scans a fixed W×H rectangle one pixel per accepted cycle, presenting `x_out`/`y_out`/`color_out` with `busy` high. The display multiplexer selects among object drawers by their `busy` flags. One instance serves each object class: player, wall, bullet and enemy.

## Interface
- `W`, default 4: rectangle width in pixels, 1..16.
- `H`, default 4: rectangle height in pixels, 1..16.
- `ERASE_COLOR`, default 3'b000: colour used when erasing the previous position.
- `clk`  in  1: system clock.
- `resetn`  in  1: reset. Asynchronous, active-low.
- `go`  in  1: start request, sampled only in IDLE.
- `x_in`  in  8: top-left x.
- `y_in`  in  7: top-left y.
- `color_in`  in  3: fill colour.
- `hold`  in  1: downstream stall. When 1, the current pixel is not accepted.
- `x_out`  out  8: pixel x.
- `y_out`  out  7: pixel y.
- `color_out`  out  3: pixel colour.
- `plot`  out  1: a valid pixel is on the outputs.
- `busy`  out  1: high in ERASE and DRAW.
- `done`  out  1: one-cycle pulse after the last pixel is accepted.

## Operation
- States: IDLE, ERASE, DRAW.
- IDLE:
  - On `go`=1, latch `x_in`, `y_in` and `color_in`, and clear the counters cx and cy.
  - Go to ERASE if that state is compiled in and `prev_valid`=1; otherwise go to DRAW.
- Scan order is row-major: cx increments 0..W-1, then cy increments and cx returns to 0.
- Outputs:
  - `x_out = base_x + cx`, modulo 256.
  - `y_out = base_y + cy`, modulo 128.
  - No clipping; coordinates wrap.
- A pixel is accepted on any rising edge where `plot`=1 and `hold`=0. Only then does the counter advance.
- When the last pixel (cx=W-1, cy=H-1) is accepted:
  - In ERASE: counters clear and the state becomes DRAW.
  - In DRAW: the state becomes IDLE, `done`=1 for one cycle, the latched position is copied to `prev_x`/`prev_y`, and `prev_valid` is set.
- `color_out` is `ERASE_COLOR` in ERASE and the latched colour in DRAW.
- `plot` = `busy`. These are registered state decodes and never depend combinationally on `hold`.
- `go` in ERASE or DRAW is ignored; it is not queued.
- `go` in the same cycle as `done` is accepted, because the state is IDLE that cycle.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, counters 0.
  - `prev_valid`=0; `prev_x`/`prev_y` 0.
- Reset mid-scan returns to IDLE immediately. The partial rectangle is abandoned. `prev_valid` is cleared, so the next draw does not erase.
- Latency: `go` sampled at edge N gives the first pixel on the outputs during cycle N+1.
- With `hold`=0 throughout:
  - `busy` stays high for W·H cycles, or 2·W·H with erase.
  - `done` rises the cycle after the last accepted pixel.
- While `hold`=1, every output and counter is frozen. Each stalled cycle extends `busy` by one.
- W=1 or H=1 are legal. A 1×1 rectangle is busy for exactly 1 cycle (without erase).

## Configuration
- `RECT_ERASE_PREV_EN` defined:
  - The ERASE state, `prev_x`, `prev_y` and `prev_valid` are compiled in.
  - Every draw after the first first repaints the previous rectangle in `ERASE_COLOR`, even if the position is unchanged.
- Undefined:
  - No ERASE state and no prev registers.
  - IDLE always proceeds to DRAW.

## Structure
- Shared package `downwell_pkg`:
  - `X_W`=8, `Y_W`=7, `C_W`=3.
  - State enum `rect_state_t`: IDLE, ERASE, DRAW.
  - Colour constants, including black = 3'b000.
- Sub-module `rect_scan_counter`:
  - Parameterised by W and H.
  - Inputs `clear` and `advance`; outputs `cx`, `cy` and `last`.
  - Instantiated once and reused for both ERASE and DRAW.

## Test plan
- W=H=2, `go` with (10,20,3'b100), `hold`=0 → `plot` for 4 cycles at (10,20), (11,20), (10,21), (11,21), colour 100; `done` on cycle 5 with `busy`=0.
- Same draw with `hold`=1 for 3 cycles while (11,20) is shown → (11,20) holds for 4 cycles; `busy` high for 7 cycles in total; same pixel sequence.
- `go` pulsed on cycle 2 of a scan → ignored; exactly 4 pixels and one `done`.
- x=255, y=127, W=H=2 → pixels (255,127), (0,127), (255,0), (0,0).
- `RECT_ERASE_PREV_EN`: draw at (10,20), then `go` at (12,20) → 4 pixels at the old rectangle with colour 000, then 4 at (12,20)..(13,21) with colour 100; `busy` for 8 cycles.
- `resetn` low during pixel 3 → all outputs 0 asynchronously; the next `go` at (5,5) draws immediately, with no erase pass.

Source files
------------

// File: rtl/downwell_pkg.sv
// Shared widths, drawer state encoding and palette for the framebuffer object drawers.
package downwell_pkg;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } rect_state_t;

    localparam logic [C_W-1:0] COLOR_BLACK   = 3'b000;
    localparam logic [C_W-1:0] COLOR_BLUE    = 3'b001;
    localparam logic [C_W-1:0] COLOR_GREEN   = 3'b010;
    localparam logic [C_W-1:0] COLOR_CYAN    = 3'b011;
    localparam logic [C_W-1:0] COLOR_RED     = 3'b100;
    localparam logic [C_W-1:0] COLOR_MAGENTA = 3'b101;
    localparam logic [C_W-1:0] COLOR_YELLOW  = 3'b110;
    localparam logic [C_W-1:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major W x H scan position counter shared by the erase and draw passes.
module rect_scan_counter
    import downwell_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned H = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic             last
);

    localparam logic [CNT_W-1:0] CX_MAX = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CY_MAX = CNT_W'(H - 1);

    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance) begin
            if (cx_q == CX_MAX) begin
                cx_d = '0;
                cy_d = (cy_q == CY_MAX) ? '0 : cy_q + CNT_W'(1);
            end else begin
                cx_d = cx_q + CNT_W'(1);
            end
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/rect_sprite_drawer.sv
// Per-object rectangle pixel emitter: scans a W x H block from a latched origin, one pixel per accept.
// Optional erase-previous-position pass is compiled in with RECT_ERASE_PREV_EN.
module rect_sprite_drawer
    import downwell_pkg::*;
#(
    parameter int unsigned     W           = 4,
    parameter int unsigned     H           = 4,
    parameter logic [C_W-1:0]  ERASE_COLOR = 3'b000
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] color_in,
    input  logic           hold,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] color_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    rect_state_t state_q, state_d;

    logic [X_W-1:0] base_x_q, base_x_d;
    logic [Y_W-1:0] base_y_q, base_y_d;
    logic [C_W-1:0] color_q, color_d;

    logic [X_W-1:0] x_out_q, x_out_d;
    logic [Y_W-1:0] y_out_q, y_out_d;
    logic [C_W-1:0] color_out_q, color_out_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic             cnt_clear, cnt_advance, cnt_last, col_end, accept;
    logic [CNT_W-1:0] cx, cy;
    logic [X_W-1:0]   org_x;
    logic [Y_W-1:0]   org_y;

    rect_scan_counter #(.W(W), .H(H)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .cx      (cx),
        .cy      (cy),
        .last    (cnt_last)
    );

`ifdef RECT_ERASE_PREV_EN
    logic [X_W-1:0] prev_x_q, prev_x_d;
    logic [Y_W-1:0] prev_y_q, prev_y_d;
    logic           prev_valid_q, prev_valid_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Erase pass scans around the previous origin, draw pass around the new one.
    assign org_x = (state_q == ERASE) ? prev_x_q : base_x_q;
    assign org_y = (state_q == ERASE) ? prev_y_q : base_y_q;
`else
    assign org_x = base_x_q;
    assign org_y = base_y_q;
`endif

    assign col_end = (cx == CNT_W'(W - 1));
    assign accept  = plot_q && !hold;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            base_x_q    <= '0;
            base_y_q    <= '0;
            color_q     <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            color_out_q <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            color_q     <= color_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            color_out_q <= color_out_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        color_d     = color_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        color_out_d = color_out_q;
        done_d      = 1'b0;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
`ifdef RECT_ERASE_PREV_EN
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    base_x_d    = x_in;
                    base_y_d    = y_in;
                    color_d     = color_in;
                    cnt_clear   = 1'b1;
                    state_d     = DRAW;
                    x_out_d     = x_in;
                    y_out_d     = y_in;
                    color_out_d = color_in;
`ifdef RECT_ERASE_PREV_EN
                    if (prev_valid_q) begin
                        state_d = ERASE;
                        x_out_d = prev_x_q;
                        y_out_d = prev_y_q;
                    end
`endif
                end
            end
            ERASE, DRAW: begin
                if (accept) begin
                    if (cnt_last) begin
                        cnt_clear = 1'b1;
                        if (state_q == ERASE) begin
                            state_d     = DRAW;
                            x_out_d     = base_x_q;
                            y_out_d     = base_y_q;
                            color_out_d = color_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
`ifdef RECT_ERASE_PREV_EN
                            prev_x_d     = base_x_q;
                            prev_y_d     = base_y_q;
                            prev_valid_d = 1'b1;
`endif
                        end
                    end else begin
                        cnt_advance = 1'b1;
                        // Next pixel position from the next counter value; both axes wrap.
                        if (col_end) begin
                            x_out_d = org_x;
                            y_out_d = org_y + Y_W'(cy) + Y_W'(1);
                        end else begin
                            x_out_d = org_x + X_W'(cx) + X_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERASE) begin
            color_out_d = ERASE_COLOR;
        end
        busy_d = (state_d != IDLE);
        plot_d = busy_d;
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign color_out = color_out_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
